// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit with direct-mapped BTB and 2-bit counters; redirects on EX mispredict.
// Optional branch statistics counters are built when FETCH_BP_STATS_EN is defined.
module fetch_pc_unit #(
  parameter int          IDX_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
`ifdef FETCH_BP_STATS_EN
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o,
`endif
  output logic        flush_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [31:0]      pc_q, pc_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, mispredict;

  // Lookup on the current fetch PC
  assign lk_idx        = pc_q[IDX_W+1:2];
  assign lk_tag        = pc_q[31:IDX_W+2];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pc_o          = pc_q;
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_o = lk_hit ? target_q[lk_idx] : 32'h0;

  assign up_idx = ex_pc_i[IDX_W+1:2];
  assign up_tag = ex_pc_i[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign mispredict = ex_branch_i &&
                      ((ex_taken_i != ex_pred_taken_i) ||
                       (ex_taken_i && ex_pred_taken_i && (ex_target_i != ex_pred_target_i)));
  assign flush_o    = mispredict;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    pc_d = pc_q + 32'd4;
    if (mispredict)        pc_d = ex_taken_i ? ex_target_i : (ex_pc_i + 32'd4);
    else if (stall_i)      pc_d = pc_q;
    else if (pred_taken_o) pc_d = pred_target_o;
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (ex_branch_i) begin
      if (ex_taken_i) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = ex_target_i;
        // A replaced or empty entry restarts at weakly-taken, then takes the increment.
        if (!up_hit)                    ctr_d[up_idx] = 2'b11;
        else if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
      end else if (up_hit && (ctr_q[up_idx] != 2'b00)) begin
        ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (rst_i) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // NOTE: tag/target storage has no reset; every read is qualified by its valid bit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

`ifdef FETCH_BP_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q  + {31'd0, ex_branch_i};
    mis_cnt_d = mis_cnt_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit (RESET_PC=0x100, IDX_W=4).
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_i, stall_i;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o, flush_o;
  logic        ex_branch_i, ex_taken_i, ex_pred_taken_i;
  logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
`ifdef FETCH_BP_STATS_EN
  logic [31:0] br_cnt_o, mispred_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.IDX_W(4), .RESET_PC(32'h100)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .pc_o             (pc_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_branch_i      (ex_branch_i),
    .ex_pc_i          (ex_pc_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
`ifdef FETCH_BP_STATS_EN
    .br_cnt_o         (br_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o),
`endif
    .flush_o          (flush_o)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] ex_pc;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic [31:0] exp_pc;
    logic        exp_pt;
    logic [31:0] exp_ptgt;
    logic        exp_flush;
  } vec_t;

  function automatic vec_t mk(logic st, logic br, logic [31:0] epc, logic tk, logic [31:0] tgt,
                              logic pt, logic [31:0] ptg, logic [31:0] xpc, logic xpt,
                              logic [31:0] xptg, logic xfl);
    vec_t v;
    v.stall = st; v.br = br; v.ex_pc = epc; v.taken = tk; v.tgt = tgt;
    v.ptaken = pt; v.ptgt = ptg; v.exp_pc = xpc; v.exp_pt = xpt;
    v.exp_ptgt = xptg; v.exp_flush = xfl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, compare pre-edge outputs, then let the rising edge commit.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst_i = 1'b0; stall_i = v.stall; ex_branch_i = v.br; ex_pc_i = v.ex_pc;
    ex_taken_i = v.taken; ex_target_i = v.tgt; ex_pred_taken_i = v.ptaken;
    ex_pred_target_i = v.ptgt;
    #1;
    check({name, ".pc"},     pc_o,                v.exp_pc);
    check({name, ".ptaken"}, 32'(pred_taken_o),   32'(v.exp_pt));
    check({name, ".ptgt"},   pred_target_o,       v.exp_ptgt);
    check({name, ".flush"},  32'(flush_o),        32'(v.exp_flush));
    @(posedge clk);
  endtask

  vec_t tbl[28];
  vec_t seq[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             st br ex_pc          tk tgt         pt ptgt        exp_pc         pt ptgt        fl
    tbl[0]  = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h100,       0, 32'h0,     0);
    tbl[1]  = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h104,       0, 32'h0,     0);
    tbl[2]  = mk(1, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h108,       0, 32'h0,     0);
    tbl[3]  = mk(1, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h108,       0, 32'h0,     0);
    tbl[4]  = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h108,       0, 32'h0,     0);
    tbl[5]  = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h10C,       0, 32'h0,     0);
    tbl[6]  = mk(0, 1, 32'h20,         1, 32'h80,    0, 32'h0,     32'h110,       0, 32'h0,     1);
    tbl[7]  = mk(0, 1, 32'h1C,         0, 32'h0,     1, 32'h0,     32'h80,        0, 32'h0,     1);
    tbl[8]  = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h20,        1, 32'h80,    0);
    tbl[9]  = mk(0, 1, 32'h20,         0, 32'h0,     1, 32'h80,    32'h80,        0, 32'h0,     1);
    tbl[10] = mk(0, 1, 32'h20,         0, 32'h0,     0, 32'h0,     32'h24,        0, 32'h0,     0);
    tbl[11] = mk(0, 1, 32'h20,         0, 32'h0,     0, 32'h0,     32'h28,        0, 32'h0,     0);
    tbl[12] = mk(1, 1, 32'h1C,         0, 32'h0,     1, 32'h0,     32'h2C,        0, 32'h0,     1);
    tbl[13] = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h20,        0, 32'h80,    0);
    tbl[14] = mk(1, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h24,        0, 32'h0,     0);
    tbl[15] = mk(0, 1, 32'h40,         1, 32'h200,   1, 32'h300,   32'h24,        0, 32'h0,     1);
    tbl[16] = mk(0, 1, 32'h40,         1, 32'h200,   1, 32'h200,   32'h200,       0, 32'h0,     0);
    tbl[17] = mk(0, 1, 32'h40,         0, 32'h0,     0, 32'h0,     32'h204,       0, 32'h0,     0);
    tbl[18] = mk(0, 1, 32'h40,         0, 32'h0,     0, 32'h0,     32'h208,       0, 32'h0,     0);
    tbl[19] = mk(0, 1, 32'h80,         1, 32'h400,   0, 32'h0,     32'h20C,       0, 32'h0,     1);
    tbl[20] = mk(0, 1, 32'h80,         0, 32'h0,     0, 32'h0,     32'h400,       0, 32'h0,     0);
    tbl[21] = mk(0, 1, 32'h7C,         0, 32'h0,     1, 32'h0,     32'h404,       0, 32'h0,     1);
    tbl[22] = mk(0, 1, 32'h80,         0, 32'h0,     0, 32'h0,     32'h80,        1, 32'h400,   0);
    tbl[23] = mk(0, 1, 32'h7C,         0, 32'h0,     1, 32'h0,     32'h400,       0, 32'h0,     1);
    tbl[24] = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h80,        0, 32'h400,   0);
    tbl[25] = mk(0, 1, 32'hFFFF_FFF8,  0, 32'h0,     1, 32'h0,     32'h84,        0, 32'h0,     1);
    tbl[26] = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'hFFFF_FFFC, 0, 32'h0,     0);
    tbl[27] = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h0,         0, 32'h0,     0);

    // After a reset that coincided with a taken-branch resolution at 0x20.
    seq[0] = mk(0, 1, 32'h1C,         0, 32'h0,     1, 32'h0,     32'h100,       0, 32'h0,     1);
    seq[1] = mk(0, 0, 32'h0,          0, 32'h0,     0, 32'h0,     32'h20,        0, 32'h0,     0);
    seq[2] = mk(0, 1, 32'h1C,         0, 32'h0,     0, 32'h0,     32'h24,        0, 32'h0,     0);
    seq[3] = mk(0, 1, 32'h1C,         0, 32'h0,     0, 32'h0,     32'h28,        0, 32'h0,     0);
    seq[4] = mk(0, 1, 32'h1C,         0, 32'h0,     0, 32'h0,     32'h2C,        0, 32'h0,     0);
    seq[5] = mk(0, 1, 32'h1C,         0, 32'h0,     1, 32'h0,     32'h30,        0, 32'h0,     1);

    rst_i = 1'b1; stall_i = 1'b0; ex_branch_i = 1'b0; ex_pc_i = 32'h0; ex_taken_i = 1'b0;
    ex_target_i = 32'h0; ex_pred_taken_i = 1'b0; ex_pred_target_i = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset.pc",     pc_o,              32'h100);
    check("reset.ptaken", 32'(pred_taken_o), 32'h0);
    check("reset.flush",  32'(flush_o),      32'h0);

    for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Reset wins over a same-cycle mispredict; flush still follows its equation.
    @(negedge clk);
    rst_i = 1'b1; stall_i = 1'b0; ex_branch_i = 1'b1; ex_pc_i = 32'h20; ex_taken_i = 1'b1;
    ex_target_i = 32'h500; ex_pred_taken_i = 1'b0; ex_pred_target_i = 32'h0;
    #1;
    check("rstmis.flush", 32'(flush_o), 32'h1);
    @(posedge clk);
    #1;
    check("rstmis.pc", pc_o, 32'h100);

    for (int i = 0; i < 6; i++) apply(seq[i], $sformatf("s%0d", i));
    #1;
`ifdef FETCH_BP_STATS_EN
    check("stats.br",  br_cnt_o,      32'd5);
    check("stats.mis", mispred_cnt_o, 32'd2);
`endif
    check("post.pc", pc_o, 32'h20);

    @(negedge clk);
    rst_i = 1'b1; ex_branch_i = 1'b0; ex_pred_taken_i = 1'b0;
    @(posedge clk);
    #1;
    check("reset2.pc", pc_o, 32'h100);
`ifdef FETCH_BP_STATS_EN
    check("reset2.br",  br_cnt_o,      32'd0);
    check("reset2.mis", mispred_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
